bpu_gshare_state: RTL and testbench

BPU_GSHARE_STATE -- requirements
Module: bpu_gshare_state

---
 rtl/bpu_gshare_state.sv | 139 +++++++++++++
 tb/tb_bpu_gshare_state.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/bpu_gshare_state.sv
// Gshare branch predictor state: flop-based PHT of 2-bit counters, global history
// register, one-outstanding predict handshake and single-cycle training port.
module bpu_gshare_state #(
  parameter int unsigned PHT_ENTRIES = 512,
  parameter int unsigned GHR_LEN     = 16,
  parameter logic [1:0]  CTR_INIT    = 2'b01
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               req_valid_i,
  output logic               req_ready_o,
  input  logic [31:0]        req_pc_i,
  output logic               resp_valid_o,
  input  logic               resp_ready_i,
  output logic               resp_taken_o,
  output logic [GHR_LEN-1:0] resp_ghr_o,
  input  logic               train_valid_i,
  input  logic [31:0]        train_pc_i,
  input  logic [GHR_LEN-1:0] train_ghr_i,
  input  logic               train_taken_i,
  input  logic               train_mispred_i,
  output logic               init_done_o
);

  localparam int unsigned IDX_W = $clog2(PHT_ENTRIES);

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   init_idx_q, init_idx_d;
  logic [GHR_LEN-1:0] ghr_q, ghr_d;
  logic [GHR_LEN-1:0] resp_ghr_q, resp_ghr_d;
  logic               resp_valid_q, resp_valid_d;
  logic               resp_taken_q, resp_taken_d;
  logic [1:0]         pht_q [PHT_ENTRIES];

  logic [IDX_W-1:0]   pred_idx, train_idx;
  logic [1:0]         pred_ctr, train_ctr;
  logic               running, req_fire, train_en, flush;

  // Same hash for predict and train so a returned GHR snapshot finds its entry.
  function automatic logic [IDX_W-1:0] pht_index(input logic [31:0]        pc,
                                                 input logic [GHR_LEN-1:0] ghr);
    return pc[IDX_W+1:2] ^ ghr[IDX_W-1:0];
  endfunction

  function automatic logic [1:0] ctr_step(input logic [1:0] ctr, input logic taken);
    if (taken) return (ctr == 2'b11) ? 2'b11 : ctr + 2'b01;
    else       return (ctr == 2'b00) ? 2'b00 : ctr - 2'b01;
  endfunction

  assign running   = (state_q == ST_RUN);
  assign pred_idx  = pht_index(req_pc_i, ghr_q);
  assign train_idx = pht_index(train_pc_i, train_ghr_i);
  assign pred_ctr  = pht_q[pred_idx];
  assign train_ctr = pht_q[train_idx];

  assign req_ready_o = running & ~resp_valid_q;
  assign req_fire    = req_valid_i & req_ready_o;
  assign train_en    = running & train_valid_i;
  assign flush       = train_en & train_mispred_i;

  // NOTE: every signal driven here gets a hold/default value first so no path
  // through the block leaves it unassigned and infers a latch.
  always_comb begin
    state_d      = state_q;
    init_idx_d   = init_idx_q;
    ghr_d        = ghr_q;
    resp_valid_d = resp_valid_q;
    resp_taken_d = resp_taken_q;
    resp_ghr_d   = resp_ghr_q;

    unique case (state_q)
      ST_INIT: begin
        init_idx_d = init_idx_q + 1'b1;
        if (init_idx_q == IDX_W'(PHT_ENTRIES - 1)) state_d = ST_RUN;
      end
      ST_RUN: ;
      default: state_d = ST_INIT;
    endcase

    // A mispredict flushes the pending response and drops a same-cycle request.
    if (flush) begin
      resp_valid_d = 1'b0;
      ghr_d        = {train_ghr_i[GHR_LEN-2:0], train_taken_i};
    end else if (req_fire) begin
      resp_valid_d = 1'b1;
      resp_taken_d = pred_ctr[1];
      resp_ghr_d   = ghr_q;
      ghr_d        = {ghr_q[GHR_LEN-2:0], pred_ctr[1]};
    end else if (resp_valid_q && resp_ready_i) begin
      resp_valid_d = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= ST_INIT;
      init_idx_q   <= '0;
      ghr_q        <= '0;
      resp_valid_q <= 1'b0;
      resp_taken_q <= 1'b0;
      resp_ghr_q   <= '0;
    end else begin
      state_q      <= state_d;
      init_idx_q   <= init_idx_d;
      ghr_q        <= ghr_d;
      resp_valid_q <= resp_valid_d;
      resp_taken_q <= resp_taken_d;
      resp_ghr_q   <= resp_ghr_d;
    end
  end

  // NOTE: the PHT has no reset; the INIT sweep writes every entry instead, which
  // keeps a reset net off 512 x 2 flops.
  always_ff @(posedge clk_i) begin
    if (state_q == ST_INIT) begin
      pht_q[init_idx_q] <= CTR_INIT;
    end else if (train_valid_i) begin
      pht_q[train_idx] <= ctr_step(train_ctr, train_taken_i);
    end
  end

  assign resp_valid_o = resp_valid_q;
  assign resp_taken_o = resp_taken_q;
  assign resp_ghr_o   = resp_ghr_q;
  assign init_done_o  = running;

  logic unused_bits;
  assign unused_bits = ^{req_pc_i[31:IDX_W+2], req_pc_i[1:0],
                         train_pc_i[31:IDX_W+2], train_pc_i[1:0],
                         train_ghr_i[GHR_LEN-1]};

endmodule

// File: tb/tb_bpu_gshare_state.sv
// Directed bench for bpu_gshare_state; responses are checked by a scoreboard
// monitor against hand-computed expectations queued by the stimulus.
module tb_bpu_gshare_state;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_pc;
  logic        resp_valid;
  logic        resp_ready;
  logic        resp_taken;
  logic [15:0] resp_ghr;
  logic        train_valid;
  logic [31:0] train_pc;
  logic [15:0] train_ghr;
  logic        train_taken;
  logic        train_mispred;
  logic        init_done;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [16:0] exp_q [$];
  logic [16:0] exp_item;

  bpu_gshare_state dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .req_valid_i    (req_valid),
    .req_ready_o    (req_ready),
    .req_pc_i       (req_pc),
    .resp_valid_o   (resp_valid),
    .resp_ready_i   (resp_ready),
    .resp_taken_o   (resp_taken),
    .resp_ghr_o     (resp_ghr),
    .train_valid_i  (train_valid),
    .train_pc_i     (train_pc),
    .train_ghr_i    (train_ghr),
    .train_taken_i  (train_taken),
    .train_mispred_i(train_mispred),
    .init_done_o    (init_done)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every consumed response is compared with the queue head.
  always @(negedge clk) begin
    if (!rst && resp_valid && resp_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_resp: got taken=%0b ghr=0x%0h, expected no response",
                 resp_taken, resp_ghr);
      end else begin
        exp_item = exp_q.pop_front();
        check("resp_taken", 32'(resp_taken), 32'(exp_item[16]));
        check("resp_ghr", 32'(resp_ghr), 32'(exp_item[15:0]));
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!req_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("req_ready_wait", 32'(req_ready), 32'd1);
  endtask

  task automatic issue(input logic [31:0] pc);
    wait_ready();
    req_valid = 1'b1;
    req_pc    = pc;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic predict(input logic [31:0] pc, input logic exp_taken, input logic [15:0] exp_ghr);
    exp_q.push_back({exp_taken, exp_ghr});
    issue(pc);
  endtask

  task automatic drive_train(input logic [31:0] pc, input logic [15:0] ghr,
                             input logic taken, input logic mispred);
    train_valid   = 1'b1;
    train_pc      = pc;
    train_ghr     = ghr;
    train_taken   = taken;
    train_mispred = mispred;
  endtask

  task automatic clear_train();
    train_valid   = 1'b0;
    train_mispred = 1'b0;
  endtask

  task automatic train(input logic [31:0] pc, input logic [15:0] ghr,
                       input logic taken, input logic mispred);
    drive_train(pc, ghr, taken, mispred);
    @(posedge clk); #1;
    clear_train();
  endtask

  // Counts edges after reset release until init_done; optionally pokes a
  // mispredict train during INIT that must be ignored.
  task automatic wait_init(input string name, input bit poke_train);
    int cnt = 0;
    while (!init_done && cnt < 1000) begin
      @(posedge clk); #1;
      cnt++;
      if (poke_train && cnt == 10) drive_train(32'h8000_0000, 16'hFFFF, 1'b1, 1'b1);
      else clear_train();
    end
    check(name, 32'(cnt), 32'd512);
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_pc = '0; resp_ready = 1'b1;
    train_valid = 1'b0; train_pc = '0; train_ghr = '0; train_taken = 1'b0; train_mispred = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_taken", 32'(resp_taken), 32'd0);
    check("rst_resp_ghr", 32'(resp_ghr), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_init_done", 32'(init_done), 32'd0);
    rst = 1'b0;
    wait_init("init_cycles", 1'b1);

    // First prediction: all counters weakly not-taken, GHR untouched by INIT train.
    predict(32'h1234_5678, 1'b0, 16'h0000);

    // Saturate entry 4 at 3, then one step down keeps it taken.
    repeat (4) train(32'h8000_0010, 16'h0000, 1'b1, 1'b0);
    predict(32'h8000_0010, 1'b1, 16'h0000);
    train(32'h8000_0010, 16'h0000, 1'b0, 1'b0);
    predict(32'h8000_0014, 1'b1, 16'h0001);

    // Floor at 0 on entry 64, then one taken step stays not-taken.
    repeat (2) train(32'h8000_0100, 16'h0000, 1'b0, 1'b0);
    predict(32'h8000_010C, 1'b0, 16'h0003);
    train(32'h8000_0100, 16'h0000, 1'b1, 1'b0);
    predict(32'h8000_0118, 1'b0, 16'h0006);

    // Pending response held, then flushed by a mispredict.
    wait_ready();
    resp_ready = 1'b0;
    issue(32'h8000_0200);
    check("hold_valid", 32'(resp_valid), 32'd1);
    check("hold_taken", 32'(resp_taken), 32'd0);
    check("hold_ghr", 32'(resp_ghr), 32'h000C);
    repeat (3) @(posedge clk);
    #1;
    check("hold_valid_later", 32'(resp_valid), 32'd1);
    check("hold_ghr_later", 32'(resp_ghr), 32'h000C);
    check("hold_req_ready", 32'(req_ready), 32'd0);
    train(32'h8000_0000, 16'h00F0, 1'b1, 1'b1);
    check("flush_valid", 32'(resp_valid), 32'd0);
    resp_ready = 1'b1;
    predict(32'h8000_0444, 1'b1, 16'h01E1);

    // Request firing in the mispredict cycle is dropped.
    wait_ready();
    req_valid = 1'b1;
    req_pc    = 32'h8000_0010;
    drive_train(32'h8000_0000, 16'h0000, 1'b0, 1'b1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    clear_train();
    check("drop_resp_valid", 32'(resp_valid), 32'd0);
    check("drop_req_ready", 32'(req_ready), 32'd1);
    predict(32'h8000_0000, 1'b0, 16'h0000);

    // Predict and train on the same index in one cycle: read sees old value.
    exp_q.push_back({1'b0, 16'h0000});
    wait_ready();
    req_valid = 1'b1;
    req_pc    = 32'h8000_04B0;
    drive_train(32'h8000_04B0, 16'h0000, 1'b1, 1'b0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    clear_train();
    predict(32'h8000_04B0, 1'b1, 16'h0000);

    // Reset mid-operation discards a pending response; re-reset at init_idx 200.
    wait_ready();
    resp_ready = 1'b0;
    issue(32'h8000_0020);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_resp_valid", 32'(resp_valid), 32'd0);
    check("midrst_init_done", 32'(init_done), 32'd0);
    check("midrst_resp_ghr", 32'(resp_ghr), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    resp_ready = 1'b1;
    repeat (200) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("rst200_init_done", 32'(init_done), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    wait_init("reinit_cycles", 1'b0);
    predict(32'h8000_0010, 1'b0, 16'h0000);
    predict(32'h8000_03C0, 1'b0, 16'h0000);

    repeat (5) @(posedge clk);
    #1;
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
